// File: rtl/vector_pkg.sv
// Shared definitions for the double-buffered display list: field layout of a
// packed vector entry, RGB565 colour constants and the commit FSM encoding.
package vector_pkg;

  localparam int COORD_W = 10;
  localparam int COL_W   = 16;
  localparam int VEC_W   = COL_W + 4 * COORD_W;

  localparam int Y1_LSB  = 0;
  localparam int X1_LSB  = 10;
  localparam int Y0_LSB  = 20;
  localparam int X0_LSB  = 30;
  localparam int COL_LSB = 40;

  localparam logic [COL_W-1:0] RED   = 16'hF800;
  localparam logic [COL_W-1:0] GREEN = 16'h07E0;
  localparam logic [COL_W-1:0] BLUE  = 16'h001F;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

endpackage

// File: rtl/vector_ram.sv
// Simple dual-port RAM holding both display-list banks; one write port and one
// enabled synchronous read port whose output register holds between reads.
module vector_ram #(
  parameter int AW = 10,
  parameter int DW = 56
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Output register resets to zero so the line engine sees blank fields after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vector_list.sv
// Double-buffered display-list controller: host fills the back bank, a commit
// swaps banks on the next frame trigger, the line engine reads the front bank.
module vector_list #(
  parameter int ADDR_W  = 9,
  parameter int COORD_W = 10,
  parameter int COL_W   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        host_we,
  input  logic [ADDR_W-1:0]           host_addr,
  input  logic [vector_pkg::VEC_W-1:0] host_wdata,
  input  logic                        host_commit,
  input  logic [ADDR_W:0]             host_len,
  output logic                        commit_pending,
  output logic                        swap,
  output logic                        front_bank,
  input  logic                        trigger,
  input  logic                        read_vector,
  input  logic [9:0]                  vector,
  output logic [COORD_W-1:0]          x0,
  output logic [COORD_W-1:0]          y0,
  output logic [COORD_W-1:0]          x1,
  output logic [COORD_W-1:0]          y1,
  output logic [COL_W-1:0]            col,
  output logic                        last_vector
);
  import vector_pkg::*;

  function automatic logic [ADDR_W:0] sat_len(input logic [ADDR_W:0] len);
    logic [ADDR_W:0] max_len;
    max_len         = '0;
    max_len[ADDR_W] = 1'b1;
    return (len > max_len) ? max_len : len;
  endfunction

  state_e          state_q, state_d;
  logic            front_bank_q, front_bank_d;
  logic            swap_q, swap_d;
  logic [ADDR_W:0] front_len_q, front_len_d;
  logic [ADDR_W:0] back_len_q, back_len_d;
  logic [ADDR_W:0] commit_len;
  logic            last_q;
  logic            rd_hit;
  logic [VEC_W-1:0] rdata;

  assign commit_len = sat_len(host_len);

  // A commit arriving together with the trigger swaps at once with its own length.
  always_comb begin
    state_d      = state_q;
    front_bank_d = front_bank_q;
    front_len_d  = front_len_q;
    back_len_d   = back_len_q;
    swap_d       = 1'b0;
    if (trigger && (host_commit || state_q == ST_PENDING)) begin
      front_bank_d = ~front_bank_q;
      front_len_d  = host_commit ? commit_len : back_len_q;
      if (host_commit) back_len_d = commit_len;
      swap_d       = 1'b1;
      state_d      = ST_IDLE;
    end else if (host_commit) begin
      back_len_d = commit_len;
      state_d    = ST_PENDING;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      front_bank_q <= 1'b0;
      front_len_q  <= '0;
      back_len_q   <= '0;
      swap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      front_bank_q <= front_bank_d;
      front_len_q  <= front_len_d;
      back_len_q   <= back_len_d;
      swap_q       <= swap_d;
    end
  end

  // Unsigned compare at 32 bits covers indices beyond the bank as misses.
  assign rd_hit = 32'(vector) < 32'(front_len_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            last_q <= 1'b1;
    else if (read_vector) last_q <= ~rd_hit;
  end

  vector_ram #(
    .AW (ADDR_W + 1),
    .DW (VEC_W)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we_i    (host_we),
    .waddr_i ({~front_bank_q, host_addr}),
    .wdata_i (host_wdata),
    .re_i    (read_vector && rd_hit),
    .raddr_i ({front_bank_q, vector[ADDR_W-1:0]}),
    .rdata_o (rdata)
  );

  assign commit_pending = (state_q == ST_PENDING);
  assign swap           = swap_q;
  assign front_bank     = front_bank_q;
  assign col            = rdata[COL_LSB +: COL_W];
  assign x0             = rdata[X0_LSB  +: COORD_W];
  assign y0             = rdata[Y0_LSB  +: COORD_W];
  assign x1             = rdata[X1_LSB  +: COORD_W];
  assign y1             = rdata[Y1_LSB  +: COORD_W];
  assign last_vector    = last_q;

endmodule

// File: tb/tb_vector_list.sv
// Directed bench for vector_list: read-back table after a first swap, then
// hand-written sequences for commit/trigger ordering, saturation and reset.
module tb_vector_list;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_we;
  logic [8:0]  host_addr;
  logic [55:0] host_wdata;
  logic        host_commit;
  logic [9:0]  host_len;
  logic        commit_pending, swap, front_bank;
  logic        trigger, read_vector;
  logic [9:0]  vector;
  logic [9:0]  x0, y0, x1, y1;
  logic [15:0] col;
  logic        last_vector;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [9:0]  vec;
    logic        last;
    logic [55:0] fields;
  } rd_t;

  rd_t tbl [5];

  always #5 clk = ~clk;

  vector_list dut (
    .clk(clk), .reset(reset), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_commit(host_commit), .host_len(host_len),
    .commit_pending(commit_pending), .swap(swap), .front_bank(front_bank),
    .trigger(trigger), .read_vector(read_vector), .vector(vector),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .col(col), .last_vector(last_vector)
  );

  function automatic logic [55:0] pack(input logic [15:0] c, input logic [9:0] a,
                                       input logic [9:0] b, input logic [9:0] d,
                                       input logic [9:0] e);
    return {c, a, b, d, e};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [8:0] a, input logic [55:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    tick();
    host_we = 1'b0;
  endtask

  task automatic rd(input logic [9:0] v, input logic exp_last,
                    input logic [55:0] exp_f, input bit chk_f, input string name);
    read_vector = 1'b1; vector = v;
    tick();
    read_vector = 1'b0;
    chk({name, ".last"}, 64'(last_vector), 64'(exp_last));
    if (chk_f) chk({name, ".fields"}, 64'({col, x0, y0, x1, y1}), 64'(exp_f));
  endtask

  initial begin
    logic [55:0] f0, f1, fs;
    reset = 1'b1; host_we = 0; host_addr = '0; host_wdata = '0; host_commit = 0;
    host_len = '0; trigger = 0; read_vector = 0; vector = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst.last", 64'(last_vector), 64'd1);
    chk("rst.front_bank", 64'(front_bank), 64'd0);
    chk("rst.pending", 64'(commit_pending), 64'd0);
    chk("rst.swap", 64'(swap), 64'd0);
    chk("rst.fields", 64'({col, x0, y0, x1, y1}), 64'd0);
    rd(10'd0, 1'b1, 56'd0, 1'b1, "rst.read0");

    // First list into bank 1, commit, then trigger
    f0 = pack(16'hF800, 10'd0, 10'd0, 10'd100, 10'd10);
    f1 = pack(16'h07E0, 10'd0, 10'd90, 10'd100, 10'd210);
    wr(9'd0, f0);
    wr(9'd1, f1);
    host_commit = 1; host_len = 10'd2;
    tick();
    host_commit = 0;
    chk("c1.pending", 64'(commit_pending), 64'd1);
    chk("c1.no_swap", 64'(swap), 64'd0);
    trigger = 1;
    tick();
    trigger = 0;
    chk("c1.swap", 64'(swap), 64'd1);
    chk("c1.front_bank", 64'(front_bank), 64'd1);
    chk("c1.pending_clr", 64'(commit_pending), 64'd0);
    tick();
    chk("c1.swap_pulse", 64'(swap), 64'd0);

    tbl[0] = '{vec: 10'd0,   last: 1'b0, fields: f0};
    tbl[1] = '{vec: 10'd1,   last: 1'b0, fields: f1};
    tbl[2] = '{vec: 10'd2,   last: 1'b1, fields: f1};
    tbl[3] = '{vec: 10'd600, last: 1'b1, fields: f1};
    tbl[4] = '{vec: 10'd0,   last: 1'b0, fields: f0};
    for (int i = 0; i < 5; i++) begin
      rd(tbl[i].vec, tbl[i].last, tbl[i].fields, 1'b1, $sformatf("tbl%0d", i));
    end

    // Last commit wins: len 5 then 3, bank 0 is back
    for (int i = 0; i < 5; i++)
      wr(9'(i), pack(16'h001F + 16'(i), 10'(i), 10'(2*i), 10'(3*i), 10'(4*i)));
    host_commit = 1; host_len = 10'd5;
    tick();
    host_len = 10'd3;
    tick();
    host_commit = 0;
    chk("c2.pending", 64'(commit_pending), 64'd1);
    trigger = 1;
    tick();
    trigger = 0;
    chk("c2.swap", 64'(swap), 64'd1);
    chk("c2.front_bank", 64'(front_bank), 64'd0);
    for (int i = 0; i < 3; i++)
      rd(10'(i), 1'b0, pack(16'h001F + 16'(i), 10'(i), 10'(2*i), 10'(3*i), 10'(4*i)),
         1'b1, $sformatf("c2.rd%0d", i));
    rd(10'd3, 1'b1, pack(16'h0021, 10'd2, 10'd4, 10'd6, 10'd8), 1'b1, "c2.rd3");

    // Commit and trigger together from IDLE
    fs = pack(16'h1234, 10'd1, 10'd2, 10'd3, 10'd4);
    wr(9'd0, fs);
    host_commit = 1; host_len = 10'd1; trigger = 1;
    tick();
    host_commit = 0; trigger = 0;
    chk("c3.swap", 64'(swap), 64'd1);
    chk("c3.pending", 64'(commit_pending), 64'd0);
    chk("c3.front_bank", 64'(front_bank), 64'd1);
    rd(10'd0, 1'b0, fs, 1'b1, "c3.rd0");
    rd(10'd1, 1'b1, fs, 1'b1, "c3.rd1");

    // Trigger with nothing pending, host writes to back bank during frame
    trigger = 1;
    tick();
    trigger = 0;
    chk("c4.no_swap", 64'(swap), 64'd0);
    chk("c4.front_bank", 64'(front_bank), 64'd1);
    wr(9'd0, pack(16'hAAAA, 10'd5, 10'd6, 10'd7, 10'd8));
    rd(10'd0, 1'b0, fs, 1'b1, "c4.rd0");

    // Oversized length saturates to 512 entries
    host_commit = 1; host_len = 10'h3FF; trigger = 1;
    tick();
    host_commit = 0; trigger = 0;
    chk("c5.front_bank", 64'(front_bank), 64'd0);
    rd(10'd0, 1'b0, pack(16'hAAAA, 10'd5, 10'd6, 10'd7, 10'd8), 1'b1, "c5.rd0");
    rd(10'd511, 1'b0, '0, 1'b0, "c5.rd511");
    rd(10'd512, 1'b1, '0, 1'b0, "c5.rd512");

    // Asynchronous reset while a commit is pending
    host_commit = 1; host_len = 10'd1;
    tick();
    host_commit = 0;
    chk("c6.pending", 64'(commit_pending), 64'd1);
    #3 reset = 1'b1;
    #1;
    chk("c6.pending_async", 64'(commit_pending), 64'd0);
    chk("c6.last_async", 64'(last_vector), 64'd1);
    chk("c6.front_bank", 64'(front_bank), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    trigger = 1;
    tick();
    trigger = 0;
    chk("c6.no_swap", 64'(swap), 64'd0);
    rd(10'd0, 1'b1, '0, 1'b0, "c6.rd0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_list.md
Name: vector_list

Overview:
- Double-buffered display-list controller that sequences the line engine frame by frame.
- The host writes vectors (endpoints plus colour) into a back bank. The line engine reads the front bank by vector number, using the existing `read_vector`/`vector` handshake.
- On a host commit, the banks swap at the next `vtrigger`, so a frame is never drawn from a half-written list.
- Replaces the hard-coded vector generator in the top level.

Parameters:
- `ADDR_W`, 9, log2 of vectors per bank. A bank holds up to 512 vectors. Total RAM is 2×2^ADDR_W entries of 56 bits.
- `COORD_W`, 10, width of each coordinate.
- `COL_W`, 16, colour width (RGB565).

Ports:
- `clk`  in  1  system clock (100 MHz domain)
- `reset`  in  1  asynchronous, active-high reset
- `host_we`  in  1  write strobe into the back bank
- `host_addr`  in  ADDR_W  back-bank entry index
- `host_wdata`  in  56  packed `{col[55:40], x0[39:30], y0[29:20], x1[19:10], y1[9:0]}`
- `host_commit`  in  1  one-cycle pulse: back bank is complete
- `host_len`  in  ADDR_W+1  vector count of the back bank; sampled on `host_commit`
- `commit_pending`  out  1  commit accepted, swap not yet done
- `swap`  out  1  one-cycle pulse in the cycle the banks swap
- `front_bank`  out  1  bank currently read by the line engine
- `trigger`  in  1  frame trigger (`vtrigger` from the vga block)
- `read_vector`  in  1  line engine requests vector `vector`
- `vector`  in  10  requested vector number
- `x0`, `y0`, `x1`, `y1`  out  COORD_W each  vector endpoints
- `col`  out  COL_W  vector colour
- `last_vector`  out  1  no vector at this index; end of list

Behaviour:
Reset:
- `front_bank`=0, `front_len`=0, `back_len`=0, `commit_pending`=0, `swap`=0.
- `x0`/`y0`/`x1`/`y1`/`col`=0, `last_vector`=1.
- RAM contents are not reset.

Host write:
- `host_we` writes `host_wdata` to RAM[{~front_bank, host_addr}] at the clock edge.
- Writes never touch the front bank.
- A write in the swap cycle goes to the bank that was back before the edge, which becomes the front bank.

Commit FSM, states IDLE and PENDING:
- IDLE → PENDING on `host_commit`; `back_len` ← `host_len`.
- PENDING + `host_commit` again: stay in PENDING; `back_len` ← new `host_len` (last commit wins).
- PENDING + `trigger`: `front_bank` toggles, `front_len` ← `back_len`, `swap`=1 for one cycle, go to IDLE.
- `host_commit` and `trigger` in the same cycle from IDLE:
  - swap happens immediately, using `host_len` directly;
  - the FSM ends in IDLE.
- `host_commit` and `trigger` in the same cycle from PENDING: same as above, using the new `host_len`.
- `trigger` in IDLE: no swap; the front list is redrawn unchanged.
- `commit_pending` is high exactly in PENDING.
- After a swap the new back bank holds stale data. The host must rewrite every entry before the next commit.

Vector read (1-cycle latency, synchronous RAM read):
- `read_vector` high in cycle N → outputs update at edge N+1 and hold until the next `read_vector`.
- If `vector` < `front_len`:
  - fields ← RAM[{front_bank, vector[ADDR_W-1:0]}];
  - `last_vector`=0.
- Otherwise (including `vector` ≥ 2^ADDR_W, or `front_len`=0):
  - `last_vector`=1;
  - coordinate and colour outputs hold their previous values.
- `read_vector` in the swap cycle uses the pre-swap `front_bank` and `front_len`.

Widths:
- `host_len` > 2^ADDR_W saturates to 2^ADDR_W.
- The `vector` comparison is unsigned, 10 bits against ADDR_W+1 bits, zero-extended.

Reset mid-operation:
- Aborts any pending commit.
- Asserts `last_vector` asynchronously.
- `front_len`=0, so the line engine draws nothing until a new commit and trigger.

Decomposition:
- Package `vector_pkg`:
  - `COORD_W`, `COL_W`;
  - packed vector field offsets;
  - colour constants RED=`16'hF800`, GREEN=`16'h07E0`, BLUE=`16'h001F`;
  - FSM state encoding.
- Sub-module `vector_ram`:
  - simple dual-port RAM, (ADDR_W+1)-bit address, 56-bit data;
  - one write port and one synchronous read port, inferable as block RAM.

Test Plan:
- Reset → `last_vector`=1, `front_bank`=0; `read_vector` with `vector`=0 one cycle later → `last_vector`=1.
- Write entry 0 = {RED,0,0,100,10}, entry 1 = {GREEN,0,90,100,210}; commit with `host_len`=2; pulse `trigger` → `swap` pulse, `front_bank`=1. Read 0 → next cycle `x1`=100, `y1`=10, `col`=`16'hF800`. Read 1 → `col`=`16'h07E0`. Read 2 → `last_vector`=1, `col` still `16'h07E0`.
- Commit `host_len`=5, then commit `host_len`=3, then `trigger` → `front_len`=3; reads 0–2 valid, read 3 → `last_vector`=1.
- `host_commit` (`host_len`=1) and `trigger` in the same cycle from IDLE → `swap` that cycle, `commit_pending` never high, read 0 valid.
- `trigger` with no pending commit → no `swap`; front data unchanged. Host writes during the frame do not alter front-bank reads.
- Assert `reset` asynchronously while PENDING → `commit_pending` drops immediately; after release, a `trigger` produces no `swap`.
